// File: rtl/reg_file_rd.sv
// Architectural register file: one write-back port, two combinational read
// ports with write-through bypass, and a per-register load scoreboard.
module reg_file_rd #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   rs1_addr,
  input  logic                rs1_used,
  input  logic [ADDR_W-1:0]   rs2_addr,
  input  logic                rs2_used,
  output logic [DATA_W-1:0]   rs1_data,
  output logic [DATA_W-1:0]   rs2_data,
  input  logic                reg_write,
  input  logic [ADDR_W-1:0]   rd_addr,
  input  logic [DATA_W-1:0]   write_data,
  input  logic                issue_load,
  input  logic [ADDR_W-1:0]   issue_rd,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic                rs1_hazard;
  logic                rs2_hazard;

  always_comb begin
    rs1_data = regs_q[rs1_addr];
    if (rs1_addr == '0) begin
      rs1_data = '0;
    end else if (reg_write && (rd_addr == rs1_addr)) begin
      rs1_data = write_data;
    end

    rs2_data = regs_q[rs2_addr];
    if (rs2_addr == '0) begin
      rs2_data = '0;
    end else if (reg_write && (rd_addr == rs2_addr)) begin
      rs2_data = write_data;
    end
  end

  // A write-back landing on the pending register this cycle is bypassed, so no hold.
  always_comb begin
    rs1_hazard = rs1_used && (rs1_addr != '0) && busy_q[rs1_addr] &&
                 !(reg_write && (rd_addr == rs1_addr));
    rs2_hazard = rs2_used && (rs2_addr != '0) && busy_q[rs2_addr] &&
                 !(reg_write && (rd_addr == rs2_addr));
    stall      = rs1_hazard || rs2_hazard;
  end

  always_comb begin
    regs_d = regs_q;
    if (reg_write && (rd_addr != '0)) begin
      regs_d[rd_addr] = write_data;
    end
    regs_d[0] = '0;

    // Clear first so a same-cycle issue to the same register wins.
    busy_d = busy_q;
    if (reg_write) begin
      busy_d[rd_addr] = 1'b0;
    end
    if (issue_load && !stall) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_reg_file_rd.sv
// Bench for reg_file_rd: an array/bitmap reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_reg_file_rd;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr, issue_rd;
  logic        rs1_used, rs2_used, reg_write, issue_load;
  logic [31:0] write_data;
  logic [31:0] rs1_data, rs2_data;
  logic        stall;
  logic [31:0] busy;

  int checks = 0;
  int errors = 0;

  reg_file_rd #(.DATA_W(32), .NUM_REGS(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs1_used(rs1_used),
    .rs2_addr(rs2_addr), .rs2_used(rs2_used),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .reg_write(reg_write), .rd_addr(rd_addr), .write_data(write_data),
    .issue_load(issue_load), .issue_rd(issue_rd),
    .stall(stall), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_regs [32];
  logic [31:0] m_busy;
  bit          model_valid = 1'b0;

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (reg_write && rd_addr == a) return write_data;
    return m_regs[a];
  endfunction

  function automatic logic m_port_stall(input logic used, input logic [4:0] a);
    return used && a != 5'd0 && m_busy[a] && !(reg_write && rd_addr == a);
  endfunction

  function automatic logic m_stall();
    return m_port_stall(rs1_used, rs1_addr) || m_port_stall(rs2_used, rs2_addr);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_busy      = 32'h0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      logic s;
      s = m_stall();
      if (reg_write && rd_addr != 5'd0) m_regs[rd_addr] = write_data;
      if (reg_write) m_busy[rd_addr] = 1'b0;
      if (issue_load && !s && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("model_rs1_data", rs1_data, m_read(rs1_addr));
      check("model_rs2_data", rs2_data, m_read(rs2_addr));
      check("model_stall", {31'b0, stall}, {31'b0, m_stall()});
      check("model_busy", busy, m_busy);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rs1_addr = '0; rs2_addr = '0; rd_addr = '0; issue_rd = '0;
    rs1_used = 1'b0; rs2_used = 1'b0; reg_write = 1'b0; issue_load = 1'b0;
    write_data = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset then read every address on both ports
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(31 - i); rs1_used = 1'b1; rs2_used = 1'b1;
      @(negedge clk);
      check("reset_rs1", rs1_data, 32'h0);
      check("reset_rs2", rs2_data, 32'h0);
      check("reset_stall", {31'b0, stall}, 32'h0);
      check("reset_busy", busy, 32'h0);
      tick();
    end

    // Write r5 with same-cycle bypass, then array readback
    reg_write = 1'b1; rd_addr = 5'd5; write_data = 32'hDEADBEEF; rs1_addr = 5'd5;
    @(negedge clk);
    check("bypass_r5", rs1_data, 32'hDEADBEEF);
    tick();
    reg_write = 1'b0;
    @(negedge clk);
    check("array_r5", rs1_data, 32'hDEADBEEF);
    tick();
    reg_write = 1'b1; rd_addr = 5'd0; write_data = 32'h12345678; rs2_addr = 5'd0;
    @(negedge clk);
    check("r0_write_bypass", rs2_data, 32'h0);
    tick();
    reg_write = 1'b0;
    @(negedge clk);
    check("r0_after_write", rs2_data, 32'h0);
    tick();

    // Load hazard on r7
    rs1_used = 1'b0; rs2_used = 1'b0;
    issue_load = 1'b1; issue_rd = 5'd7;
    tick();
    issue_load = 1'b0; rs2_addr = 5'd7; rs2_used = 1'b1;
    @(negedge clk);
    check("hazard_stall", {31'b0, stall}, 32'h1);
    check("hazard_busy", busy, 32'h0000_0080);
    tick();
    rs2_used = 1'b0;
    @(negedge clk);
    check("unused_no_stall", {31'b0, stall}, 32'h0);
    tick();
    rs2_used = 1'b1; reg_write = 1'b1; rd_addr = 5'd7; write_data = 32'hA5A5A5A5;
    @(negedge clk);
    check("wb_stall_drop", {31'b0, stall}, 32'h0);
    check("wb_bypass_r7", rs2_data, 32'hA5A5A5A5);
    tick();
    reg_write = 1'b0; rs2_used = 1'b0;
    @(negedge clk);
    check("wb_busy_clear", busy, 32'h0);
    tick();

    // Set/clear collision on r9
    issue_load = 1'b1; issue_rd = 5'd9;
    tick();
    reg_write = 1'b1; rd_addr = 5'd9; write_data = 32'h0000_0999;
    @(negedge clk);
    check("collide_stall", {31'b0, stall}, 32'h0);
    tick();
    reg_write = 1'b0; issue_load = 1'b0;
    @(negedge clk);
    check("collide_busy9", busy, 32'h0000_0200);
    tick();

    // r3 = 0x55, then a pending load on r3 gates a new issue to r4
    reg_write = 1'b1; rd_addr = 5'd3; write_data = 32'h55;
    tick();
    reg_write = 1'b0; issue_load = 1'b1; issue_rd = 5'd3;
    tick();
    rs1_addr = 5'd3; rs1_used = 1'b1; issue_rd = 5'd4;
    @(negedge clk);
    check("gated_stall", {31'b0, stall}, 32'h1);
    tick();
    issue_load = 1'b0; rs1_used = 1'b0;
    @(negedge clk);
    check("gated_busy4", busy, 32'h0000_0208);
    tick();
    issue_load = 1'b1; issue_rd = 5'd0;
    tick();
    issue_load = 1'b0;
    @(negedge clk);
    check("issue_r0_busy", busy, 32'h0000_0208);
    check("r3_value", rs1_data, 32'h55);
    tick();

    // Reset with concurrent write and issue
    rst = 1'b1; reg_write = 1'b1; rd_addr = 5'd3; write_data = 32'h77;
    issue_load = 1'b1; issue_rd = 5'd5;
    tick();
    rst = 1'b0; reg_write = 1'b0; issue_load = 1'b0; rs1_addr = 5'd3; rs2_addr = 5'd5;
    @(negedge clk);
    check("rst_mid_busy", busy, 32'h0);
    check("rst_mid_r3", rs1_data, 32'h0);
    check("rst_mid_r5", rs2_data, 32'h0);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
